des_perm_stream: RTL and testbench
==================================

Name: des_perm_stream

Overview:
- Streaming DES bit-permutation engine for the cipher datapath. Applies the initial permutation (IP), the final permutation (IP^-1), IP^-1 with L/R pre-swap, or bypass to 64-bit blocks.
- Uses a valid/ready handshake, an optional internal pipeline register and an output FIFO.
- Sits between the block source/key-schedule round core and the output formatter. Successor to the fixed combinational IP stage: adds mode select, buffering, flow control and a block counter.

Parameters:
- DEPTH, 4, output FIFO entries; power of 2, range 2..16.
- PIPE, 0, 1 inserts a register between accept and FIFO write (adds 1 cycle latency); 0 writes the FIFO in the cycle after accept.
- CNT_W, 16, width of the processed-block counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pipe and FIFO contents.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_data  in  64  input block.
- in_mode  in  2  mode for this block: 00 bypass, 01 IP, 10 IP^-1, 11 IP^-1 of {in_data[31:0],in_data[63:32]}.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  64  FIFO head block.
- fifo_level  out  $clog2(DEPTH)+1  entries currently held.
- blk_cnt  out  CNT_W  blocks popped since reset, wraps.

Behaviour:
- Bit numbering: DES bit n (1..64, 1 = MSB) = vector index 64-n. Out-of-range indices never occur.
- IP: output bit i = input bit IP[i]. IP table rows are 58 50 42 34 26 18 10 2 / 60 52 .. 4 / 62 .. 6 / 64 .. 8 / 57 .. 1 / 59 .. 3 / 61 .. 5 / 63 .. 7.
- IP^-1: the exact inverse table (40 8 48 16 56 24 64 32 / 39 7 ...). FP(IP(x)) = x for all x.
- Accept: in_valid & in_ready at a rising edge. in_mode and in_data are sampled together; mode is per block, with no sticky mode state.
- Permutation is combinational on sampled data and registered at accept (stage A).
  - PIPE=0: stage A writes the FIFO on the next edge.
  - PIPE=1: stage A feeds stage B, which writes the FIFO.
- Latency: accept at edge t gives out_valid high after edge t+1+PIPE, provided the FIFO was empty.
- in_ready = (fifo_level + inflight) < DEPTH, where inflight = occupied pipe stages. It is registered or derived from state only; there is no combinational path from out_ready.
- FIFO full: in_ready = 0 even if out_ready = 1 in the same cycle. Throughput of 1 block/cycle is sustained whenever level < DEPTH-1-PIPE.
- Pop: out_valid & out_ready. The head advances and blk_cnt increments by 1, wrapping 2^CNT_W-1 -> 0.
- Simultaneous push and pop: level is unchanged and data order is preserved.
- out_data holds the head value while out_valid=1 and out_ready=0; it must not change until popped.
- out_data when empty: holds its last value, with 0 after reset. Consumers must not sample it.
- Pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.
- flush (synchronous, highest priority):
  - Next edge: pipe stages empty, FIFO empty, fifo_level = 0, out_valid = 0.
  - Any accept or pop in the flush cycle is discarded, and blk_cnt is not incremented.
  - blk_cnt is not cleared by flush.
- Reset (async assert, held while rst_n = 0): in_ready = 0, out_valid = 0, out_data = 0, fifo_level = 0, blk_cnt = 0, pipe empty.
  - Reset asserted mid-stream drops all in-flight and buffered blocks immediately.
  - in_ready rises on the first edge after rst_n deasserts.
- Inputs changing while in_valid = 1 and in_ready = 0 are ignored; only accepted values matter.

Test Plan:
- Known vector: in_data = 0x0123456789ABCDEF, mode 01, PIPE=0 -> out_data = 0xCC00CCFFF0AAF0AA, out_valid one edge after accept, blk_cnt = 1 after pop.
- Inverse: in_data = 0xCC00CCFFF0AAF0AA mode 10 -> 0x0123456789ABCDEF. Mode 11 with 0xF0AAF0AACC00CCFF -> 0x0123456789ABCDEF. Mode 00 -> input unchanged.
- Single-bit walk: for each n in 1..64, drive input bit n alone in mode 01 -> exactly output bit IP^-1-position set (e.g. bit 58 (0x40) -> 0x8000000000000000). Then check the mode 10 round trip.
- Backpressure, DEPTH=4, PIPE=1: hold out_ready = 0 and stream 10 blocks -> exactly 4 accepted and in_ready = 0. Release out_ready -> all blocks out in order, none lost or duplicated, mixed modes per block correct.
- Full boundary: FIFO full, out_ready = 1 and in_valid = 1 in the same cycle -> pop occurs and no accept that cycle. Accept occurs on the next cycle and level returns to DEPTH.
- Flush and reset mid-stream: with 3 blocks buffered, pulse flush -> level 0, out_valid 0, blk_cnt unchanged. Then assert rst_n = 0 between edges -> outputs 0 immediately and blk_cnt = 0. With CNT_W=4, pop 17 blocks -> blk_cnt = 1.

Source files
------------

// File: rtl/des_perm_stream.sv
// Streaming DES IP / IP^-1 / swapped IP^-1 / bypass engine with a reserved-slot output FIFO.
// Latency is 1+PIPE cycles into an empty FIFO; in_ready comes only from state, never from out_ready.
module des_perm_stream #(
  parameter int DEPTH = 4,
  parameter int PIPE  = 0,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_data,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         blk_cnt
);

  localparam int PW = $clog2(DEPTH);

  // DES bit n (1 = MSB) lives at vector index 64-n.
  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  di;
    logic [5:0]  si;
    int          src;
    y = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        src   = (r < 4) ? (58 + 2 * r - 8 * c) : (57 + 2 * (r - 4) - 8 * c);
        di    = 6'(63 - 8 * r - c);
        si    = 6'(64 - src);
        y[di] = x[si];
      end
    end
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  di;
    logic [5:0]  si;
    int          src;
    y = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        src   = ((c % 2) == 0) ? (40 - r + 8 * (c / 2)) : (8 - r + 8 * (c / 2));
        di    = 6'(63 - 8 * r - c);
        si    = 6'(64 - src);
        y[di] = x[si];
      end
    end
    return y;
  endfunction

  logic              rdy_en_q;
  logic              a_vld_q, a_vld_d;
  logic [63:0]       a_dat_q, a_dat_d;
  logic              b_vld_q, b_vld_d;
  logic [63:0]       b_dat_q, b_dat_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       level_q, level_d;
  logic [63:0]       last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       mem_q [DEPTH];

  logic [63:0]       perm;
  logic [63:0]       push_dat;
  logic [63:0]       head;
  logic              push;
  logic              pop;
  logic              accept;
  logic [PW+1:0]     occ;

  always_comb begin
    perm = in_data;
    case (in_mode)
      2'b01:   perm = ip_perm(in_data);
      2'b10:   perm = fp_perm(in_data);
      2'b11:   perm = fp_perm({in_data[31:0], in_data[63:32]});
      default: perm = in_data;
    endcase
  end

  // Pipe stages count against capacity, so blocks in flight always have a FIFO slot.
  assign occ       = {1'b0, level_q} + (PW+2)'(a_vld_q) + (PW+2)'(b_vld_q);
  assign in_ready  = rdy_en_q && (occ < (PW+2)'(DEPTH));
  assign out_valid = (level_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign out_data  = out_valid ? head : last_q;
  assign fifo_level = level_q;
  assign blk_cnt   = cnt_q;

  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign push     = (PIPE != 0) ? b_vld_q : a_vld_q;
  assign push_dat = (PIPE != 0) ? b_dat_q : a_dat_q;

  always_comb begin
    a_vld_d  = accept && !flush;
    a_dat_d  = accept ? perm : a_dat_q;
    b_vld_d  = (PIPE != 0) && a_vld_q && !flush;
    b_dat_d  = a_vld_q ? a_dat_q : b_dat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      level_d  = level_q + (PW+1)'(push) - (PW+1)'(pop);
      if (pop) begin
        last_d = head;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      a_vld_q  <= 1'b0;
      a_dat_q  <= '0;
      b_vld_q  <= 1'b0;
      b_dat_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      a_vld_q  <= a_vld_d;
      a_dat_q  <= a_dat_d;
      b_vld_q  <= b_vld_d;
      b_dat_q  <= b_dat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is masked by level, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: tb/tb_des_perm_stream.sv
// Directed bench: instance A (PIPE=0) for permutation vectors, instance B (PIPE=1, CNT_W=4) for flow control.
module tb_des_perm_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic [63:0] a_in_data = '0;
  logic [1:0]  a_in_mode = '0;
  logic        a_in_ready, a_out_valid;
  logic [63:0] a_out_data;
  logic [2:0]  a_level;
  logic [15:0] a_cnt;

  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic [63:0] b_in_data = '0;
  logic [1:0]  b_in_mode = '0;
  logic        b_in_ready, b_out_valid;
  logic [63:0] b_out_data;
  logic [2:0]  b_level;
  logic [3:0]  b_cnt;

  int checks = 0;
  int errors = 0;
  logic [63:0] rx_q[$];

  int fp_tab [64] = '{40, 8, 48, 16, 56, 24, 64, 32,
                      39, 7, 47, 15, 55, 23, 63, 31,
                      38, 6, 46, 14, 54, 22, 62, 30,
                      37, 5, 45, 13, 53, 21, 61, 29,
                      36, 4, 44, 12, 52, 20, 60, 28,
                      35, 3, 43, 11, 51, 19, 59, 27,
                      34, 2, 42, 10, 50, 18, 58, 26,
                      33, 1, 41,  9, 49, 17, 57, 25};

  des_perm_stream #(.DEPTH(4), .PIPE(0), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .fifo_level(a_level), .blk_cnt(a_cnt));

  des_perm_stream #(.DEPTH(4), .PIPE(1), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .fifo_level(b_level), .blk_cnt(b_cnt));

  // Reference: output bit FP[n] of IP carries input bit n.
  function automatic logic [63:0] model(input logic [63:0] x, input logic [1:0] m);
    logic [63:0] s, y;
    s = (m == 2'b11) ? {x[31:0], x[63:32]} : x;
    y = s;
    if (m == 2'b01) begin
      for (int n = 1; n <= 64; n++) y[6'(64 - fp_tab[n-1])] = s[6'(64 - n)];
    end else if (m[1]) begin
      for (int n = 1; n <= 64; n++) y[6'(64 - n)] = s[6'(64 - fp_tab[n-1])];
    end
    return y;
  endfunction

  function automatic logic [63:0] blk(input int k);
    return 64'h0123456789ABCDEF + 64'(k) * 64'h0F1E2D3C4B5A6978;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_xfer(input logic [63:0] d, input logic [1:0] m, output logic [63:0] q);
    int w;
    a_in_data = d; a_in_mode = m; a_in_valid = 1'b1;
    w = 0;
    while (!a_in_ready && w < 10) begin tick(); w++; end
    tick();
    a_in_valid = 1'b0;
    w = 0;
    while (!a_out_valid && w < 10) begin tick(); w++; end
    q = a_out_valid ? a_out_data : 64'bx;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic b_drain(input int n);
    int w;
    rx_q.delete();
    b_out_ready = 1'b1;
    w = 0;
    while (rx_q.size() < n && w < 40) begin
      if (b_out_valid) rx_q.push_back(b_out_data);
      tick();
      w++;
    end
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b/%b exp 0/0", a_in_ready, b_in_ready); end
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 64'h0) begin errors++; $display("FAIL reset_out: got %b %h exp 0 0", a_out_valid, a_out_data); end
    checks++; if (b_level !== 3'd0 || b_cnt !== 4'd0 || a_cnt !== 16'd0) begin errors++; $display("FAIL reset_level_cnt: got %0d %0d %0d exp 0 0 0", b_level, b_cnt, a_cnt); end
    rst_n = 1'b1;
    #2;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b exp 0", a_in_ready); end
    tick();
    checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b/%b exp 1/1", a_in_ready, b_in_ready); end
  endtask

  task automatic test_known_vector();
    a_in_data = 64'h0123456789ABCDEF; a_in_mode = 2'b01; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL kv_early_valid: got %b exp 0", a_out_valid); end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_level !== 3'd1) begin errors++; $display("FAIL kv_latency: got valid %b level %0d exp 1 1", a_out_valid, a_level); end
    checks++; if (a_out_data !== 64'hCC00CCFFF0AAF0AA) begin errors++; $display("FAIL kv_data: got %h exp cc00ccfff0aaf0aa", a_out_data); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    checks++; if (a_cnt !== 16'd1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL kv_pop: got cnt %0d valid %b exp 1 0", a_cnt, a_out_valid); end
    checks++; if (a_out_data !== 64'hCC00CCFFF0AAF0AA) begin errors++; $display("FAIL kv_hold_empty: got %h exp cc00ccfff0aaf0aa", a_out_data); end
  endtask

  task automatic test_inverse();
    logic [63:0] q;
    a_xfer(64'hCC00CCFFF0AAF0AA, 2'b10, q);
    checks++; if (q !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL inv_mode10: got %h exp 0123456789abcdef", q); end
    a_xfer(64'hF0AAF0AACC00CCFF, 2'b11, q);
    checks++; if (q !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL inv_mode11: got %h exp 0123456789abcdef", q); end
    a_xfer(64'hDEADBEEF01234567, 2'b00, q);
    checks++; if (q !== 64'hDEADBEEF01234567) begin errors++; $display("FAIL bypass: got %h exp deadbeef01234567", q); end
  endtask

  task automatic test_walk();
    logic [63:0] d, e, q, r;
    for (int n = 1; n <= 64; n++) begin
      d = 64'd1 << (64 - n);
      e = 64'd1 << (64 - fp_tab[n-1]);
      a_xfer(d, 2'b01, q);
      checks++; if (q !== e) begin errors++; $display("FAIL walk_ip bit %0d: got %h exp %h", n, q, e); end
      a_xfer(q, 2'b10, r);
      checks++; if (r !== d) begin errors++; $display("FAIL walk_roundtrip bit %0d: got %h exp %h", n, r, d); end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    b_out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      b_in_valid = 1'b1; b_in_data = blk(k); b_in_mode = 2'(k);
      if (b_in_ready) acc++;
      if (k == 2) begin
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL pipe_latency_early: got %b exp 0", b_out_valid); end
      end
      if (k == 3) begin
        checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL pipe_latency: got %b exp 1", b_out_valid); end
      end
      tick();
    end
    b_in_valid = 1'b0;
    repeat (2) tick();
    checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d exp 4", acc); end
    checks++; if (b_level !== 3'd4 || b_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got level %0d ready %b exp 4 0", b_level, b_in_ready); end
    b_drain(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== model(blk(i), 2'(i))) begin
        errors++; $display("FAIL bp_order %0d: got %h exp %h", i, (i < rx_q.size()) ? rx_q[i] : 64'bx, model(blk(i), 2'(i)));
      end
    end
    repeat (2) tick();
    checks++; if (b_out_valid !== 1'b0 || b_cnt !== 4'd4) begin errors++; $display("FAIL bp_after: got valid %b cnt %0d exp 0 4", b_out_valid, b_cnt); end
  endtask

  task automatic test_full_boundary();
    logic [63:0] exp_q [5];
    for (int k = 0; k < 4; k++) begin
      b_in_valid = 1'b1; b_in_data = blk(20 + k); b_in_mode = 2'(k);
      tick();
    end
    b_in_valid = 1'b0;
    repeat (2) tick();
    checks++; if (b_level !== 3'd4) begin errors++; $display("FAIL fb_fill: got %0d exp 4", b_level); end
    b_in_valid = 1'b1; b_in_data = blk(30); b_in_mode = 2'b11; b_out_ready = 1'b1;
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL fb_no_accept: got %b exp 0", b_in_ready); end
    checks++; if (b_out_data !== model(blk(20), 2'd0)) begin errors++; $display("FAIL fb_head: got %h exp %h", b_out_data, model(blk(20), 2'd0)); end
    tick();
    b_out_ready = 1'b0;
    checks++; if (b_level !== 3'd3 || b_cnt !== 4'd5) begin errors++; $display("FAIL fb_pop: got level %0d cnt %0d exp 3 5", b_level, b_cnt); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL fb_ready_next: got %b exp 1", b_in_ready); end
    tick();
    b_in_valid = 1'b0;
    checks++; if (b_level !== 3'd3 || b_in_ready !== 1'b0) begin errors++; $display("FAIL fb_inflight: got level %0d ready %b exp 3 0", b_level, b_in_ready); end
    repeat (2) tick();
    checks++; if (b_level !== 3'd4) begin errors++; $display("FAIL fb_refull: got %0d exp 4", b_level); end
    exp_q[0] = model(blk(21), 2'd1); exp_q[1] = model(blk(22), 2'd2);
    exp_q[2] = model(blk(23), 2'd3); exp_q[3] = model(blk(30), 2'b11);
    b_drain(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL fb_order %0d: got %h exp %h", i, (i < rx_q.size()) ? rx_q[i] : 64'bx, exp_q[i]);
      end
    end
    tick();
    checks++; if (b_out_valid !== 1'b0 || b_cnt !== 4'd9) begin errors++; $display("FAIL fb_after: got valid %b cnt %0d exp 0 9", b_out_valid, b_cnt); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      b_in_valid = 1'b1; b_in_data = blk(40 + k); b_in_mode = 2'(k);
      tick();
    end
    b_in_valid = 1'b0;
    repeat (3) tick();
    checks++; if (b_level !== 3'd3) begin errors++; $display("FAIL fl_buffered: got %0d exp 3", b_level); end
    b_flush = 1'b1; b_in_valid = 1'b1; b_in_data = blk(45); b_out_ready = 1'b1;
    tick();
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    checks++; if (b_level !== 3'd0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL fl_empty: got level %0d valid %b exp 0 0", b_level, b_out_valid); end
    checks++; if (b_cnt !== 4'd9 || b_in_ready !== 1'b1) begin errors++; $display("FAIL fl_cnt_ready: got cnt %0d ready %b exp 9 1", b_cnt, b_in_ready); end
    repeat (2) tick();
    checks++; if (b_level !== 3'd0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL fl_no_stray: got level %0d valid %b exp 0 0", b_level, b_out_valid); end
  endtask

  task automatic test_midstream_reset();
    for (int k = 0; k < 2; k++) begin
      b_in_valid = 1'b1; b_in_data = blk(50 + k); b_in_mode = 2'(k);
      tick();
    end
    b_in_valid = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (b_out_valid !== 1'b0 || b_out_data !== 64'h0 || b_level !== 3'd0) begin errors++; $display("FAIL rst_out: got %b %h %0d exp 0 0 0", b_out_valid, b_out_data, b_level); end
    checks++; if (b_cnt !== 4'd0 || a_cnt !== 16'd0 || b_in_ready !== 1'b0) begin errors++; $display("FAIL rst_cnt: got %0d %0d ready %b exp 0 0 0", b_cnt, a_cnt, b_in_ready); end
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b exp 0", b_in_ready); end
    tick();
    checks++; if (b_in_ready !== 1'b1 || b_level !== 3'd0) begin errors++; $display("FAIL rst_ready_rise: got ready %b level %0d exp 1 0", b_in_ready, b_level); end
  endtask

  task automatic test_wrap();
    int sent, got, stalls, cyc;
    logic [63:0] e;
    sent = 0; got = 0; stalls = 0; cyc = 0;
    b_out_ready = 1'b1;
    while (got < 17 && cyc < 200) begin
      if (b_out_valid) begin
        e = model(blk(60 + got), 2'(got));
        checks++; if (b_out_data !== e) begin errors++; $display("FAIL wrap_data %0d: got %h exp %h", got, b_out_data, e); end
        got++;
      end
      b_in_valid = (sent < 17); b_in_data = blk(60 + sent); b_in_mode = 2'(sent);
      if (sent < 17) begin
        if (b_in_ready) sent++;
        else stalls++;
      end
      tick();
      cyc++;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    checks++; if (got !== 17 || stalls !== 0) begin errors++; $display("FAIL wrap_stream: got pops %0d stalls %0d exp 17 0", got, stalls); end
    checks++; if (b_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt: got %0d exp 1", b_cnt); end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_inverse();
    test_walk();
    test_backpressure();
    test_full_boundary();
    test_flush();
    test_midstream_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
